// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - 3x3 sliding window generator over a raster pixel stream
module window_line_buffer #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int DATA_WIDTH = 8,
    localparam int CW = $clog2(IMG_WIDTH),
    localparam int RW = $clog2(IMG_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    input  logic                    pixel_in_valid,
    output logic [9*DATA_WIDTH-1:0] window_out,
    output logic                    window_valid,
    output logic                    frame_done,
    output logic [CW-1:0]           col_idx,
    output logic [RW-1:0]           row_idx
);

    // lb1 holds the previous row, lb0 the row before that, both indexed by column
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win [3][3];

    logic accept;
    logic last_col;
    logic last_row;

    // clear takes priority over an incoming pixel, which is then dropped
    assign accept   = pixel_in_valid && !clear;
    assign last_col = (col_idx == CW'(IMG_WIDTH - 1));
    assign last_row = (row_idx == RW'(IMG_HEIGHT - 1));

    // Raster position of the next expected pixel, wrapping at row and frame ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_idx <= '0;
            row_idx <= '0;
        end else if (clear) begin
            col_idx <= '0;
            row_idx <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_idx <= '0;
                row_idx <= last_row ? '0 : row_idx + RW'(1);
            end else begin
                col_idx <= col_idx + CW'(1);
            end
        end
    end

    // Window/frame pulses; col>=2 and row>=2 gating hides stale or wrapped data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= accept && (row_idx >= RW'(2)) && (col_idx >= CW'(2));
            frame_done   <= accept && last_col && last_row;
        end
    end

    // Shift the 3x3 window left and load the new right column from the line buffers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0[col_idx];
            win[1][2] <= lb1[col_idx];
            win[2][2] <= pixel_in;
        end
    end

    // Line buffer update, reading old contents in the same cycle they are replaced
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_idx] <= lb1[col_idx];
            lb1[col_idx] <= pixel_in;
        end
    end

    // Flatten the window so w[r][c] sits at slot r*3+c
    always_comb begin
        window_out = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window_out[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_window_line_buffer.sv
// tb/tb_window_line_buffer.sv - scoreboard bench for window_line_buffer (4x4 and 5x3 instances)
module tb_window_line_buffer;

    typedef struct {
        logic [71:0] win;
        logic        done;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear_a = 1'b0, v_a = 1'b0, clear_b = 1'b0, v_b = 1'b0;
    logic [7:0]  p_a = '0, p_b = '0;
    logic [71:0] win_a, win_b;
    logic        wv_a, fd_a, wv_b, fd_b;
    logic [1:0]  col_a, row_a, row_b;
    logic [2:0]  col_b;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    int          nwin[2];
    int          nfd[2];
    logic [71:0] first_win[2];
    logic [71:0] last_win[2];
    int          mcol[2], mrow[2], mw[2], mh[2];
    logic [7:0]  img[2][8][8];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    window_line_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_WIDTH(8)) u_dut_a (
        .clk(clk), .reset(reset), .clear(clear_a), .pixel_in(p_a), .pixel_in_valid(v_a),
        .window_out(win_a), .window_valid(wv_a), .frame_done(fd_a), .col_idx(col_a), .row_idx(row_a)
    );

    window_line_buffer #(.IMG_WIDTH(5), .IMG_HEIGHT(3), .DATA_WIDTH(8)) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear_b), .pixel_in(p_b), .pixel_in_valid(v_b),
        .window_out(win_b), .window_valid(wv_b), .frame_done(fd_b), .col_idx(col_b), .row_idx(row_b)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        mcol[d] = 0;
        mrow[d] = 0;
    endtask

    task automatic model_accept(input int d, input logic [7:0] pix);
        exp_t e;
        img[d][mrow[d]][mcol[d]] = pix;
        if (mrow[d] >= 2 && mcol[d] >= 2) begin
            e.win = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.win[(r*3+c)*8 +: 8] = img[d][mrow[d]-2+r][mcol[d]-2+c];
            e.done = (mrow[d] == mh[d]-1) && (mcol[d] == mw[d]-1);
            e.due  = cyc + 1;
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (mcol[d] == mw[d]-1) begin
            mcol[d] = 0;
            mrow[d] = (mrow[d] == mh[d]-1) ? 0 : mrow[d] + 1;
        end else begin
            mcol[d] = mcol[d] + 1;
        end
    endtask

    task automatic send(input int d, input logic [7:0] pix, input logic clr = 1'b0);
        if (d == 0) begin p_a = pix; v_a = 1'b1; clear_a = clr; end
        else begin p_b = pix; v_b = 1'b1; clear_b = clr; end
        if (clr) model_reset(d);
        else model_accept(d, pix);
        @(posedge clk); #1;
        v_a = 1'b0; clear_a = 1'b0; v_b = 1'b0; clear_b = 1'b0;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("a_col_hold", 128'(col_a), 128'(mcol[0]));
            check("a_row_hold", 128'(row_a), 128'(mrow[0]));
        end
    endtask

    task automatic scen_start;
        nwin[0] = 0; nwin[1] = 0; nfd[0] = 0; nfd[1] = 0;
    endtask

    // Scoreboard for the 4x4 instance: every cycle either an expected window is due or nothing may pulse
    always @(negedge clk) begin
        exp_t e;
        logic ev;
        if (!reset) begin
            ev = (q0.size() > 0) && (q0[0].due == cyc);
            check("a_valid", 128'(wv_a), 128'(ev));
            if (ev) begin
                e = q0.pop_front();
                check("a_window", 128'(win_a), 128'(e.win));
                check("a_done", 128'(fd_a), 128'(e.done));
                if (nwin[0] == 0) first_win[0] = win_a;
                last_win[0] = win_a;
                nwin[0]++;
            end else begin
                check("a_done_idle", 128'(fd_a), 128'(0));
            end
            if (fd_a) nfd[0]++;
        end
    end

    // Scoreboard for the 5x3 instance
    always @(negedge clk) begin
        exp_t e;
        logic ev;
        if (!reset) begin
            ev = (q1.size() > 0) && (q1[0].due == cyc);
            check("b_valid", 128'(wv_b), 128'(ev));
            if (ev) begin
                e = q1.pop_front();
                check("b_window", 128'(win_b), 128'(e.win));
                check("b_done", 128'(fd_b), 128'(e.done));
                if (nwin[1] == 0) first_win[1] = win_b;
                last_win[1] = win_b;
                nwin[1]++;
            end else begin
                check("b_done_idle", 128'(fd_b), 128'(0));
            end
            if (fd_b) nfd[1]++;
        end
    end

    initial begin
        logic [71:0] w_first_4x4;
        logic [71:0] w_first_5x3;
        logic [71:0] w_last_5x3;
        w_first_4x4 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        w_first_5x3 = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
        w_last_5x3  = {8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7, 8'd4, 8'd3, 8'd2};
        mw[0] = 4; mh[0] = 4; mw[1] = 5; mh[1] = 3;
        model_reset(0);
        model_reset(1);
        scen_start();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_window", 128'(win_a), 128'(0));
        check("rst_valid", 128'(wv_a), 128'(0));
        check("rst_done", 128'(fd_a), 128'(0));
        check("rst_col", 128'(col_a), 128'(0));
        check("rst_row", 128'(row_a), 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // consecutive 4x4 frame
        scen_start();
        for (int i = 0; i < 16; i++) send(0, 8'(i));
        idle_a(3);
        check("s1_nwin", 128'(nwin[0]), 128'(4));
        check("s1_nfd", 128'(nfd[0]), 128'(1));
        check("s1_first", 128'(first_win[0]), 128'(w_first_4x4));

        // same frame with gaps
        scen_start();
        for (int i = 0; i < 16; i++) begin
            send(0, 8'(i));
            idle_a(i == 7 ? 5 : 1);
        end
        idle_a(2);
        check("s2_nwin", 128'(nwin[0]), 128'(4));
        check("s2_nfd", 128'(nfd[0]), 128'(1));
        check("s2_first", 128'(first_win[0]), 128'(w_first_4x4));

        // back-to-back frames
        scen_start();
        for (int i = 0; i < 32; i++) send(0, 8'(i));
        idle_a(3);
        check("s3_nwin", 128'(nwin[0]), 128'(8));
        check("s3_nfd", 128'(nfd[0]), 128'(2));

        // reset mid-frame
        scen_start();
        for (int i = 0; i < 7; i++) send(0, 8'(i));
        reset = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check("mrst_window", 128'(win_a), 128'(0));
        check("mrst_valid", 128'(wv_a), 128'(0));
        check("mrst_col", 128'(col_a), 128'(0));
        check("mrst_row", 128'(row_a), 128'(0));
        check("mrst_nwin", 128'(nwin[0]), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        check("mrst_hold_done", 128'(fd_a), 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) send(0, 8'(i));
        idle_a(3);
        check("s4_nwin", 128'(nwin[0]), 128'(4));
        check("s4_first", 128'(first_win[0]), 128'(w_first_4x4));

        // clear colliding with pixel 9
        scen_start();
        for (int i = 0; i < 9; i++) send(0, 8'(i));
        send(0, 8'd9, 1'b1);
        check("clr_col", 128'(col_a), 128'(0));
        check("clr_row", 128'(row_a), 128'(0));
        for (int i = 0; i < 16; i++) send(0, 8'(i));
        idle_a(3);
        check("s5_nwin", 128'(nwin[0]), 128'(4));
        check("s5_nfd", 128'(nfd[0]), 128'(1));
        check("s5_first", 128'(first_win[0]), 128'(w_first_4x4));

        // 5x3 image
        scen_start();
        for (int i = 0; i < 15; i++) send(1, 8'(i));
        repeat (3) @(posedge clk);
        #1;
        check("s6_nwin", 128'(nwin[1]), 128'(3));
        check("s6_nfd", 128'(nfd[1]), 128'(1));
        check("s6_first", 128'(first_win[1]), 128'(w_first_5x3));
        check("s6_last", 128'(last_win[1]), 128'(w_last_5x3));

        check("q_a_empty", 128'(q0.size()), 128'(0));
        check("q_b_empty", 128'(q1.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
